// File: rtl/layer_sequencer.sv
// layer_sequencer: steps one convolutional layer pass over the neuron/kernel
// buffers, conv unit and pooling write-back. Per output row it clears the
// accumulators, walks every channel/tap pair, waits out the conv pipeline and
// writes the row back; at layer end it pulses done and flips the ping-pong
// neuron buffers.
module layer_sequencer #(
  parameter int ABuffer  = 11,
  parameter int CW       = 8,
  parameter int CONV_LAT = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               start,
  input  logic [CW-1:0]      cfgChannels,
  input  logic [CW-1:0]      cfgRows,
  input  logic [3:0]         cfgTaps,
  input  logic               cfgPool,
  input  logic [ABuffer-1:0] cfgReadBase,
  input  logic [ABuffer-1:0] cfgWriteBase,
  input  logic [ABuffer-1:0] cfgKernelBase,
  output logic               busy,
  output logic               done,
  output logic [ABuffer-1:0] nReadAddress,
  output logic [ABuffer-1:0] kBuffAddress,
  output logic [ABuffer-1:0] nWriteAddress,
  output logic               nWWrite,
  output logic               convAccClear,
  output logic               convAccEnable,
  output logic               doPooling,
  output logic               readBufferSelect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Last drain count value; unused when the conv pipeline has no latency.
  localparam logic [3:0] DRAIN_LAST = 4'((CONV_LAT > 0) ? CONV_LAT - 1 : 0);

  state_t             state_reg;
  logic [CW-1:0]      chans_reg;
  logic [CW-1:0]      rows_reg;
  logic [3:0]         taps_reg;
  logic               pool_reg;
  logic [ABuffer-1:0] write_base_reg;
  logic [ABuffer-1:0] kernel_base_reg;
  logic [ABuffer-1:0] stride_reg;    // channel stride R+T-1
  logic [ABuffer-1:0] row_base_reg;  // readBase + r
  logic [ABuffer-1:0] chan_ptr_reg;  // readBase + c*S + r
  logic [CW-1:0]      r_reg;
  logic [CW-1:0]      c_reg;
  logic [3:0]         t_reg;
  logic [3:0]         drain_reg;

  logic               degenerate;
  logic               write_hit;
  logic [ABuffer-1:0] write_addr;

  // Write-back decision for the current row and zero-size config detection.
  // Address sums wrap modulo 2^ABuffer, so computing them directly at
  // ABuffer bits gives the same truncated result as a wider sum.
  always_comb begin
    degenerate = (cfgChannels == '0) || (cfgRows == '0) || (cfgTaps == 4'd0);
    write_hit  = pool_reg ? r_reg[0] : 1'b1;
    write_addr = write_base_reg +
                 (pool_reg ? ABuffer'(r_reg >> 1) : ABuffer'(r_reg));
  end

  // Sequencer FSM with registered datapath controls; addresses are advanced
  // incrementally so no multipliers are needed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg        <= S_IDLE;
      chans_reg        <= '0;
      rows_reg         <= '0;
      taps_reg         <= '0;
      pool_reg         <= 1'b0;
      write_base_reg   <= '0;
      kernel_base_reg  <= '0;
      stride_reg       <= '0;
      row_base_reg     <= '0;
      chan_ptr_reg     <= '0;
      r_reg            <= '0;
      c_reg            <= '0;
      t_reg            <= '0;
      drain_reg        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      nReadAddress     <= '0;
      kBuffAddress     <= '0;
      nWriteAddress    <= '0;
      nWWrite          <= 1'b0;
      convAccClear     <= 1'b0;
      convAccEnable    <= 1'b0;
      doPooling        <= 1'b0;
      readBufferSelect <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            chans_reg       <= cfgChannels;
            rows_reg        <= cfgRows;
            taps_reg        <= cfgTaps;
            pool_reg        <= cfgPool;
            write_base_reg  <= cfgWriteBase;
            kernel_base_reg <= cfgKernelBase;
            stride_reg      <= ABuffer'(cfgRows) + ABuffer'(cfgTaps) - ABuffer'(1);
            row_base_reg    <= cfgReadBase;
            r_reg           <= '0;
            busy            <= 1'b1;
            doPooling       <= cfgPool;
            if (degenerate) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end else begin
              state_reg    <= S_CLEAR;
              convAccClear <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          convAccClear  <= 1'b0;
          convAccEnable <= 1'b1;
          nReadAddress  <= row_base_reg;
          chan_ptr_reg  <= row_base_reg;
          kBuffAddress  <= kernel_base_reg;
          c_reg         <= '0;
          t_reg         <= '0;
          state_reg     <= S_MAC;
        end

        S_MAC: begin
          if (t_reg != taps_reg - 4'd1) begin
            // next tap of the same channel: both addresses step by one
            t_reg        <= t_reg + 4'd1;
            nReadAddress <= nReadAddress + ABuffer'(1);
            kBuffAddress <= kBuffAddress + ABuffer'(1);
          end else if (c_reg != chans_reg - CW'(1)) begin
            // next channel: jump read pointer by one channel stride
            c_reg        <= c_reg + CW'(1);
            t_reg        <= 4'd0;
            chan_ptr_reg <= chan_ptr_reg + stride_reg;
            nReadAddress <= chan_ptr_reg + stride_reg;
            kBuffAddress <= kBuffAddress + ABuffer'(1);
          end else begin
            convAccEnable <= 1'b0;
            if (CONV_LAT == 0) begin
              state_reg <= S_WRITE;
              nWWrite   <= write_hit;
              if (write_hit) nWriteAddress <= write_addr;
            end else begin
              state_reg <= S_DRAIN;
              drain_reg <= DRAIN_LAST;
            end
          end
        end

        S_DRAIN: begin
          if (drain_reg == 4'd0) begin
            state_reg <= S_WRITE;
            nWWrite   <= write_hit;
            if (write_hit) nWriteAddress <= write_addr;
          end else begin
            drain_reg <= drain_reg - 4'd1;
          end
        end

        S_WRITE: begin
          nWWrite <= 1'b0;
          if (r_reg != rows_reg - CW'(1)) begin
            r_reg        <= r_reg + CW'(1);
            row_base_reg <= row_base_reg + ABuffer'(1);
            convAccClear <= 1'b1;
            state_reg    <= S_CLEAR;
          end else begin
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end

        S_DONE: begin
          done             <= 1'b0;
          busy             <= 1'b0;
          doPooling        <= 1'b0;
          readBufferSelect <= ~readBufferSelect;
          state_reg        <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed scenarios plus random configs, each
// compared cycle by cycle against a trace built from the layer loop nest.
module tb_layer_sequencer;
  localparam int AB  = 11;
  localparam int CW  = 8;
  localparam int LAT = 2;
  localparam int AMASK = (1 << AB) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfgChannels = '0;
  logic [CW-1:0] cfgRows = '0;
  logic [3:0]    cfgTaps = '0;
  logic          cfgPool = 1'b0;
  logic [AB-1:0] cfgReadBase = '0;
  logic [AB-1:0] cfgWriteBase = '0;
  logic [AB-1:0] cfgKernelBase = '0;
  logic          busy, done, nWWrite, convAccClear, convAccEnable;
  logic          doPooling, readBufferSelect;
  logic [AB-1:0] nReadAddress, kBuffAddress, nWriteAddress;

  layer_sequencer #(.ABuffer(AB), .CW(CW), .CONV_LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .cfgChannels(cfgChannels), .cfgRows(cfgRows), .cfgTaps(cfgTaps),
    .cfgPool(cfgPool), .cfgReadBase(cfgReadBase), .cfgWriteBase(cfgWriteBase),
    .cfgKernelBase(cfgKernelBase), .busy(busy), .done(done),
    .nReadAddress(nReadAddress), .kBuffAddress(kBuffAddress),
    .nWriteAddress(nWriteAddress), .nWWrite(nWWrite),
    .convAccClear(convAccClear), .convAccEnable(convAccEnable),
    .doPooling(doPooling), .readBufferSelect(readBufferSelect)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit clr;
    bit en;
    bit wr;
    bit dn;
    int ra;
    int ka;
    int wa;
  } step_t;

  step_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    exp_rbs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wr"}, 32'(nWWrite), 0);
    check({tag, "_clr"}, 32'(convAccClear), 0);
    check({tag, "_en"}, 32'(convAccEnable), 0);
    check({tag, "_pool"}, 32'(doPooling), 0);
    check({tag, "_rbs"}, 32'(readBufferSelect), 0);
    check({tag, "_ra"}, 32'(nReadAddress), 0);
    check({tag, "_ka"}, 32'(kBuffAddress), 0);
    check({tag, "_wa"}, 32'(nWriteAddress), 0);
  endtask

  // Expected busy-cycle trace written straight from the layer loop nest.
  task automatic build_model(input int c, input int r, input int t, input bit pool,
                             input int rb, input int wb, input int kb);
    step_t s;
    int stride;
    q.delete();
    stride = r + t - 1;
    if (c == 0 || r == 0 || t == 0) begin
      s = '{clr:0, en:0, wr:0, dn:1, ra:0, ka:0, wa:0};
      q.push_back(s);
      return;
    end
    for (int row = 0; row < r; row++) begin
      s = '{clr:1, en:0, wr:0, dn:0, ra:0, ka:0, wa:0};
      q.push_back(s);
      for (int ch = 0; ch < c; ch++) begin
        for (int tap = 0; tap < t; tap++) begin
          s = '{clr:0, en:1, wr:0, dn:0,
                ra:(rb + ch * stride + row + tap) & AMASK,
                ka:(kb + ch * t + tap) & AMASK, wa:0};
          q.push_back(s);
        end
      end
      for (int d = 0; d < LAT; d++) begin
        s = '{clr:0, en:0, wr:0, dn:0, ra:0, ka:0, wa:0};
        q.push_back(s);
      end
      if (pool)
        s = '{clr:0, en:0, wr:(row % 2 == 1), dn:0, ra:0, ka:0, wa:(wb + row / 2) & AMASK};
      else
        s = '{clr:0, en:0, wr:1, dn:0, ra:0, ka:0, wa:(wb + row) & AMASK};
      q.push_back(s);
    end
    s = '{clr:0, en:0, wr:0, dn:1, ra:0, ka:0, wa:0};
    q.push_back(s);
  endtask

  task automatic compare_step(input step_t s, input bit pool, input int idx);
    check("busy", 32'(busy), 1);
    check("clear", 32'(convAccClear), 32'(s.clr));
    check("enable", 32'(convAccEnable), 32'(s.en));
    check("write", 32'(nWWrite), 32'(s.wr));
    check("done", 32'(done), 32'(s.dn));
    check("dopool", 32'(doPooling), 32'(pool));
    check("rbs_busy", 32'(readBufferSelect), 32'(exp_rbs));
    if (s.en) begin
      check("raddr", 32'(nReadAddress), 32'(s.ra));
      check("kaddr", 32'(kBuffAddress), 32'(s.ka));
    end
    if (s.wr) check("waddr", 32'(nWriteAddress), 32'(s.wa));
    if (idx < 0) $display("unreachable");
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic run_pass(input int c, input int r, input int t, input bit pool,
                          input int rb, input int wb, input int kb, input bit poke);
    cfgChannels   = CW'(c);
    cfgRows       = CW'(r);
    cfgTaps       = 4'(t);
    cfgPool       = pool;
    cfgReadBase   = AB'(rb);
    cfgWriteBase  = AB'(wb);
    cfgKernelBase = AB'(kb);
    start         = 1'b1;
    build_model(c, r, t, pool, rb, wb, kb);
    @(negedge CLK);
    start = 1'b0;
    // scramble config: it must already be latched
    cfgChannels   = CW'($urandom);
    cfgRows       = CW'($urandom);
    cfgTaps       = 4'($urandom);
    cfgPool       = 1'($urandom);
    cfgReadBase   = AB'($urandom);
    cfgWriteBase  = AB'($urandom);
    cfgKernelBase = AB'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge CLK);
      if (poke) start = (i == 2);
      compare_step(q[i], pool, i);
    end
    start = 1'b0;
    @(negedge CLK);
    exp_rbs = ~exp_rbs;
    check("busy_after", 32'(busy), 0);
    check("done_after", 32'(done), 0);
    check("pool_after", 32'(doPooling), 0);
    check("rbs_after", 32'(readBufferSelect), 32'(exp_rbs));
    $display("pass C=%0d R=%0d T=%0d pool=%0d rb=%0d wb=%0d kb=%0d cycles=%0d rbs=%0d",
             c, r, t, pool, rb, wb, kb, q.size(), exp_rbs);
  endtask

  initial begin
    // reset state
    #12;
    check_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check_zero("idle");

    // basic pass, then back-to-back second layer (start in the IDLE cycle)
    run_pass(2, 3, 3, 1'b0, 0, 100, 500, 1'b0);
    run_pass(2, 3, 3, 1'b0, 0, 100, 500, 1'b0);

    // pooling with odd row count
    run_pass(1, 5, 1, 1'b1, 40, 300, 7, 1'b0);

    // degenerate configurations
    run_pass(0, 3, 2, 1'b0, 5, 6, 7, 1'b0);
    run_pass(3, 0, 2, 1'b1, 5, 6, 7, 1'b0);
    run_pass(2, 2, 0, 1'b0, 5, 6, 7, 1'b0);

    // wrap-around with a stray start mid-pass
    run_pass(1, 2, 2, 1'b0, 2046, 2047, 2045, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      check("stray_start_busy", 32'(busy), 0);
      check("stray_start_done", 32'(done), 0);
    end

    // asynchronous reset during MAC of row 1
    cfgChannels = 8'd2; cfgRows = 8'd3; cfgTaps = 4'd3; cfgPool = 1'b0;
    cfgReadBase = 11'd0; cfgWriteBase = 11'd100; cfgKernelBase = 11'd500;
    start = 1'b1;
    build_model(2, 3, 3, 1'b0, 0, 100, 500);
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      start = 1'b0;
      compare_step(q[i], 1'b0, i);
    end
    #2;
    nRST = 1'b0;
    #1;
    check_zero("async_reset");
    exp_rbs = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("rst_hold_done", 32'(done), 0);
      check("rst_hold_busy", 32'(busy), 0);
    end
    nRST = 1'b1;
    @(negedge CLK);
    check_zero("post_reset_idle");
    $display("reset mid-pass applied, rbs=%0d", exp_rbs);
    run_pass(2, 3, 3, 1'b0, 0, 100, 500, 1'b0);

    // randomized configurations
    for (int k = 0; k < 12; k++) begin
      run_pass(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 5)), 1'($urandom),
               int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
               int'($urandom_range(0, AMASK)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences one convolutional layer pass over the neuron-buffer / kernel-buffer / convolutional-unit / pooling datapath.
- For each output row, generates neuron-read and kernel addresses across all input channels and kernel taps, and drives accumulator clear/enable.
- After each row it waits out the convolutional-unit pipeline, then issues the write-back.
- At layer end it swaps the ping-pong neuron buffers and pulses done. It sits between the master controller (config + start) and the datapath control ports.

Parameters:
- ABuffer, 11, neuron/kernel buffer address width
- CW, 8, width of configuration count fields
- CONV_LAT, 2, cycles from last accumulate to partial sum valid at pooling-unit input (0..15)

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- start  input  1  begin a layer pass; sampled only in IDLE
- cfgChannels  input  CW  number of input channels C
- cfgRows  input  CW  output rows R per channel
- cfgTaps  input  4  kernel taps T (rows of kernel)
- cfgPool  input  1  enable 2:1 row pooling on write-back
- cfgReadBase  input  ABuffer  read-buffer base address
- cfgWriteBase  input  ABuffer  write-buffer base address
- cfgKernelBase  input  ABuffer  kernel-buffer base address
- busy  output  1  high from cycle after accepted start until DONE exits
- done  output  1  one-cycle completion pulse
- nReadAddress  output  ABuffer  neuron read address
- kBuffAddress  output  ABuffer  kernel buffer address
- nWriteAddress  output  ABuffer  neuron write address
- nWWrite  output  1  write strobe to write buffer
- convAccClear  output  1  clear conv-unit accumulators
- convAccEnable  output  1  accumulate current operands
- doPooling  output  1  pooling path select (= latched cfgPool while busy)
- readBufferSelect  output  1  ping-pong selector; toggles at each layer completion

Behaviour:
- Reset (nRST low, any time, including mid-pass):
  - state IDLE; all outputs 0, readBufferSelect included.
  - Counters cleared; in-flight pass abandoned with no done pulse.
- Config latch: at the edge where start=1 in IDLE, all cfg* are latched. Inputs are ignored thereafter until IDLE; start while busy is ignored.
- Degenerate config (C=0, R=0 or T=0): IDLE -> DONE directly, so busy=1 for one cycle with done=1; no accumulate or write strobes. readBufferSelect still toggles.
- States: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE.
  - IDLE -> CLEAR on start.
  - CLEAR: one cycle, convAccClear=1 -> MAC.
  - MAC: C*T cycles, convAccEnable=1.
    - Inner loop is tap t (0..T-1); outer loop is channel c (0..C-1).
    - Input channel stride S = R+T-1.
    - nReadAddress = cfgReadBase + c*S + r + t.
    - kBuffAddress = cfgKernelBase + c*T + t.
    - Addresses are valid in the same cycle as convAccEnable.
  - DRAIN: CONV_LAT cycles with all strobes 0 (skipped when CONV_LAT=0) -> WRITE.
  - WRITE: one cycle.
    - Without pooling: nWWrite=1, nWriteAddress = cfgWriteBase + r.
    - With pooling: nWWrite=1 only when r is odd, nWriteAddress = cfgWriteBase + (r>>1).
    - Then: if r<R-1, r++ -> CLEAR; else -> DONE.
  - DONE: one cycle, done=1, busy=1. On exit, readBufferSelect toggles, busy=0, state IDLE.
- Pooling with odd R: the final even row is accumulated but never written (dropped).
- Arithmetic: all address sums are computed at ≥ ABuffer+CW bits and truncated modulo 2^ABuffer (wrap-around permitted, no error). Products C*T and c*S do not overflow internal counters for the maximum CW/4-bit fields.
- Latency: busy cycles = R*(C*T + CONV_LAT + 2) + 1.
- Address outputs hold their last value when not strobed; they are registered (no combinational input-to-output path).
- doPooling is 0 in IDLE.

Test Plan:
- Basic pass: C=2, R=3, T=3, bases 0/100/500, no pool, CONV_LAT=2.
  - Each row has 1 clear + 6 MAC + 2 drain + 1 write; busy for 31 cycles.
  - Row 1 MAC read sequence is 1,2,3,6,7,8; kernel sequence is 500..505.
  - Writes go to 100,101,102; one done pulse; readBufferSelect 0->1.
- Pooling: C=1, R=5, T=1, cfgPool=1.
  - nWWrite asserted only for rows 1 and 3, at writeBase+0 and writeBase+1.
  - Row 4 is not written; doPooling=1 throughout busy.
- Degenerate: C=0 with start.
  - Next cycle busy=1, done=1 for one cycle, no strobes, readBufferSelect toggles.
- Reset mid-pass: deassert nRST during MAC of row 1.
  - All outputs go to 0 immediately, asynchronously; no done pulse.
  - A fresh start afterwards runs a full pass from r=0.
- Start while busy plus wrap-around: cfgReadBase=2046, C=1, R=2, T=2.
  - Read addresses are 2046,2047 then 2047,0.
  - A second start pulse mid-pass is ignored (exactly one done pulse).
- Back-to-back layers: start reasserted in the cycle after DONE.
  - Accepted; readBufferSelect toggles twice overall (1 then 0).
